sobel_stream_engine: RTL
========================

Name: sobel_stream_engine

Overview:
- Parametrised streaming 3x3 Sobel convolution engine for NCH-channel raster images of IMG_W x IMG_H pixels.
- Accepts one multi-channel pixel per cycle and buffers two rows internally.
- Emits one valid-window result per accepted pixel once the window is filled: (IMG_W-2)*(IMG_H-2) results per frame.
- Successor to the fixed 128x128 RGB processor. Adds selectable output mode, input gaps (valid-qualified), frame-done and busy status, and a generic channel count.

Parameters:
- IMG_W, 128, pixels per row (>=3)
- IMG_H, 128, rows per frame (>=3)
- PIX_W, 8, bits per channel sample (unsigned)
- NCH, 3, channel count (>=1)
- OUT_W (localparam), PIX_W+$clog2(NCH)+4, signed result width (14 for defaults)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; ignored while busy
- mode  in  2  0=Gx, 1=Gy, 2=|Gx|+|Gy|, 3=|Gx|+|Gy| saturated to 2^PIX_W-1; latched on start
- in_valid  in  1  in_pix valid this cycle
- in_pix  in  NCH*PIX_W  channel c at bits [c*PIX_W +: PIX_W]
- out_pix  out  OUT_W  signed result
- out_valid  out  1  out_pix valid
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame

Behaviour:
- Reset (async, reset=0): out_pix=0, out_valid=0, busy=0, frame_done=0; row/col counters, pipeline valids and window registers cleared. Line-buffer RAM contents need not be cleared.
- Reset mid-frame aborts the frame. There is no partial output after release, and a new start is required.
- Idle: in_valid is ignored while busy=0.
- start while idle sets busy on the next edge and latches mode. start while busy is ignored; the latched mode holds for the whole frame.
- Accepted pixel = in_valid & busy.
- Accepted pixels are in raster order. Counters col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accepted pixels; col wraps to 0 and row increments.
- in_valid gaps of any length are legal. They stall nothing; they produce matching gaps on out_valid.
- Window: p[r][c], r,c in 0..2. Row 0 is the oldest, column 2 is the newest; p[2][2] is the pixel just accepted.
- A window is valid when the accepted pixel has row>=2 and col>=2. Windows never straddle a row wrap.
- Per-channel sums:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20)
  - Gy = (p20+2p21+p22)-(p00+2p01+p02)
  - Gx and Gy are each summed over all NCH channels at full precision, with no truncation.
- Mode output: mode 0 gives Gx; mode 1 gives Gy; mode 2 gives |Gx|+|Gy|; mode 3 gives min(|Gx|+|Gy|, 2^PIX_W-1). All results are sign-extended or zero-extended to OUT_W.
- Pipeline, 5 registered stages:
  - S1 window shift
  - S2 per-channel row/column weighted sums
  - S3 per-channel Gx/Gy
  - S4 channel accumulate
  - S5 mode select/abs/saturate into out_pix
- Latency: a valid window completed by the pixel accepted on edge k has out_valid=1 and its out_pix after edge k+5 (LAT=5).
- out_pix holds its last value when out_valid=0.
- Frame end: the accepted pixel at (IMG_H-1, IMG_W-1) is the last one. Its result asserts out_valid and frame_done together; busy drops on the same edge.
- After the last pixel is accepted, further in_valid is ignored. Results still in the pipeline drain normally.
- A start issued in the cycle after the last pixel is accepted is honoured only once busy=0; a start before busy has dropped is ignored.

Decomposition:
- Package sobel_pkg:
  - mode enum (SOBEL_GX, SOBEL_GY, SOBEL_MAG, SOBEL_MAG_SAT)
  - LAT=5
  - function out_width(PIX_W,NCH)
- Sub-module sobel_line_buffer (IMG_W, NCH*PIX_W):
  - two-row delay memory, written and read on accepted pixels only
  - supplies column {row-2,row-1,current} to the window shifter

Test Plan:
- Constant image 100 on all channels, IMG_W=8, IMG_H=6, mode 0 -> 24 outputs all 0; frame_done on the 24th; busy low afterwards.
- Horizontal ramp pix=col on all 3 channels, mode 0 -> every output 24 (8 per channel). Mode 1 -> 0. Mode 2 -> 24.
- Vertical step: rows 0-2 = 0, rows 3-5 = 255, mode 1 -> output rows 1-2 give 3060. Mode 3 -> 255 (saturated).
- Random in_valid gaps (~50%) on the ramp image -> the same 24 values of 24 in the same order. Each value arrives exactly 5 edges after its bottom-right pixel.
- Reset asserted after 20 pixels of a frame -> all outputs 0 immediately. A new start plus a full frame gives correct results; start pulses while busy have no effect.
- Back-to-back frames with a mode change (0 then 1) at the second start -> the first frame is all Gx, the second all Gy; two frame_done pulses.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel engine.
package sobel_pkg;

  typedef enum logic [1:0] {
    SOBEL_GX      = 2'd0,
    SOBEL_GY      = 2'd1,
    SOBEL_MAG     = 2'd2,
    SOBEL_MAG_SAT = 2'd3
  } sobel_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } eng_state_e;

  localparam int LAT = 5;

  // Signed result width that holds both the channel-summed gradients and |Gx|+|Gy|.
  function automatic int out_width(input int pix_w, input int nch);
    return pix_w + $clog2(nch) + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row delay line: on each accepted pixel, emits the column {row-2, row-1, current}.
module sobel_line_buffer #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        din,
  output logic                     col_valid,
  output logic [DATA_W-1:0]        col_top,
  output logic [DATA_W-1:0]        col_mid,
  output logic [DATA_W-1:0]        col_bot
);

  logic [DATA_W-1:0] row1_mem [DEPTH];
  logic [DATA_W-1:0] row2_mem [DEPTH];

  // Row storage: the previous row slides down into the older row on each write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      row1_mem[addr] <= din;
      row2_mem[addr] <= row1_mem[addr];
    end
  end

  // Registered column output, one strobe per accepted pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_valid <= 1'b0;
      col_top   <= '0;
      col_mid   <= '0;
      col_bot   <= '0;
    end else begin
      col_valid <= wr_en;
      if (wr_en) begin
        col_top <= row2_mem[addr];
        col_mid <= row1_mem[addr];
        col_bot <= din;
      end
    end
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel engine: raster multi-channel pixels in, one gradient result
// per complete window out, five registered stages after the accepting edge.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int NCH   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  input  logic [NCH*PIX_W-1:0]             in_pix,
  output logic [out_width(PIX_W, NCH)-1:0] out_pix,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int OUT_W  = out_width(PIX_W, NCH);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int SW     = PIX_W + 2;
  localparam int DW     = PIX_W + 3;
  localparam int EXT    = OUT_W - DW;
  localparam int DATA_W = NCH * PIX_W;

  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]    COL_TWO  = CW'(2);
  localparam logic [RW-1:0]    ROW_TWO  = RW'(2);
  localparam logic [OUT_W-1:0] SAT_MAX  = OUT_W'((1 << PIX_W) - 1);

  eng_state_e  state_r;
  sobel_mode_e mode_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic accept_s;

  logic              lb_valid_s;
  logic [DATA_W-1:0] lb_top_s, lb_mid_s, lb_bot_s;

  logic        s0_win_r, s0_last_r;
  sobel_mode_e s0_mode_r;

  logic [DATA_W-1:0] win_r [3][3];
  logic        v1_r, v2_r, v3_r, v4_r;
  logic        last1_r, last2_r, last3_r, last4_r;
  sobel_mode_e mode1_r, mode2_r, mode3_r, mode4_r;

  logic [SW-1:0]        left2_r [NCH];
  logic [SW-1:0]        right2_r[NCH];
  logic [SW-1:0]        top2_r  [NCH];
  logic [SW-1:0]        bot2_r  [NCH];
  logic signed [DW-1:0] gx3_r   [NCH];
  logic signed [DW-1:0] gy3_r   [NCH];
  logic signed [OUT_W-1:0] gx_sum_s, gy_sum_s, gx4_r, gy4_r;
  logic [OUT_W-1:0] abs_x_s, abs_y_s, mag_s, res_s;

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] e);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, e};
  endfunction

  assign accept_s = in_valid & (state_r == ST_RUN);

  // Frame control: start latches mode, raster counters advance on accepted pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      mode_r  <= SOBEL_GX;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
            mode_r  <= sobel_mode_e'(mode);
            col_r   <= '0;
            row_r   <= '0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                row_r   <= '0;
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept_s),
    .addr      (col_r),
    .din       (in_pix),
    .col_valid (lb_valid_s),
    .col_top   (lb_top_s),
    .col_mid   (lb_mid_s),
    .col_bot   (lb_bot_s)
  );

  // Side-band travelling with the line-buffer column; mode rides along so a
  // new frame's mode never touches results still draining from the old one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_win_r  <= 1'b0;
      s0_last_r <= 1'b0;
      s0_mode_r <= SOBEL_GX;
    end else begin
      s0_win_r  <= accept_s & (row_r >= ROW_TWO) & (col_r >= COL_TWO);
      s0_last_r <= accept_s & (row_r == ROW_LAST) & (col_r == COL_LAST);
      if (accept_s) begin
        s0_mode_r <= mode_r;
      end
    end
  end

  // S1 window shift plus valid/last/mode pipeline for all stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          win_r[r][k] <= '0;
        end
      end
      {v1_r, v2_r, v3_r, v4_r}             <= 4'b0000;
      {last1_r, last2_r, last3_r, last4_r} <= 4'b0000;
      mode1_r <= SOBEL_GX;
      mode2_r <= SOBEL_GX;
      mode3_r <= SOBEL_GX;
      mode4_r <= SOBEL_GX;
    end else begin
      if (lb_valid_s) begin
        for (int r = 0; r < 3; r++) begin
          win_r[r][0] <= win_r[r][1];
          win_r[r][1] <= win_r[r][2];
        end
        win_r[0][2] <= lb_top_s;
        win_r[1][2] <= lb_mid_s;
        win_r[2][2] <= lb_bot_s;
      end
      {v1_r, v2_r, v3_r, v4_r}             <= {s0_win_r, v1_r, v2_r, v3_r};
      {last1_r, last2_r, last3_r, last4_r} <= {s0_last_r, last1_r, last2_r, last3_r};
      mode1_r <= s0_mode_r;
      mode2_r <= mode1_r;
      mode3_r <= mode2_r;
      mode4_r <= mode3_r;
    end
  end

  // S2 weighted column/row sums and S3 per-channel gradients.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        left2_r[c]  <= '0;
        right2_r[c] <= '0;
        top2_r[c]   <= '0;
        bot2_r[c]   <= '0;
        gx3_r[c]    <= '0;
        gy3_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        left2_r[c]  <= wsum(win_r[0][0][c*PIX_W +: PIX_W], win_r[1][0][c*PIX_W +: PIX_W],
                            win_r[2][0][c*PIX_W +: PIX_W]);
        right2_r[c] <= wsum(win_r[0][2][c*PIX_W +: PIX_W], win_r[1][2][c*PIX_W +: PIX_W],
                            win_r[2][2][c*PIX_W +: PIX_W]);
        top2_r[c]   <= wsum(win_r[0][0][c*PIX_W +: PIX_W], win_r[0][1][c*PIX_W +: PIX_W],
                            win_r[0][2][c*PIX_W +: PIX_W]);
        bot2_r[c]   <= wsum(win_r[2][0][c*PIX_W +: PIX_W], win_r[2][1][c*PIX_W +: PIX_W],
                            win_r[2][2][c*PIX_W +: PIX_W]);
        gx3_r[c]    <= $signed({1'b0, right2_r[c]}) - $signed({1'b0, left2_r[c]});
        gy3_r[c]    <= $signed({1'b0, bot2_r[c]}) - $signed({1'b0, top2_r[c]});
      end
    end
  end

  // Channel accumulation at full precision.
  always_comb begin
    gx_sum_s = '0;
    gy_sum_s = '0;
    for (int c = 0; c < NCH; c++) begin
      gx_sum_s = gx_sum_s + {{EXT{gx3_r[c][DW-1]}}, gx3_r[c]};
      gy_sum_s = gy_sum_s + {{EXT{gy3_r[c][DW-1]}}, gy3_r[c]};
    end
  end

  // Mode select with magnitude and saturation.
  always_comb begin
    abs_x_s = gx4_r[OUT_W-1] ? -gx4_r : gx4_r;
    abs_y_s = gy4_r[OUT_W-1] ? -gy4_r : gy4_r;
    mag_s   = abs_x_s + abs_y_s;
    case (mode4_r)
      SOBEL_GX:      res_s = gx4_r;
      SOBEL_GY:      res_s = gy4_r;
      SOBEL_MAG:     res_s = mag_s;
      SOBEL_MAG_SAT: res_s = (mag_s > SAT_MAX) ? SAT_MAX : mag_s;
      default:       res_s = '0;
    endcase
  end

  // S4 accumulate register and S5 output register; out_pix holds between results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gx4_r      <= '0;
      gy4_r      <= '0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      gx4_r      <= gx_sum_s;
      gy4_r      <= gy_sum_s;
      out_valid  <= v4_r;
      frame_done <= v4_r & last4_r;
      if (v4_r) begin
        out_pix <= res_s;
      end
    end
  end

endmodule
